// File: rtl/rca_multiword_adder_pkg.sv
// Shared definitions for the sequential multi-word ripple-carry adder.
// Holds the FSM state encoding, the adder slice width and the
// index-width helper used to size the nibble counter.
package rca_multiword_adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ceil(log2(n)), never less than 1 so a single-slice build still has an index bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/RIPPLE_CARRY_ADDER.sv
// Existing 4-bit ripple-carry adder slice, purely combinational.
// Ports: A, B (4-bit operands), Cin (carry-in), SUM (4-bit), CARRY (carry-out).
module RIPPLE_CARRY_ADDER
  import rca_multiword_adder_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             Cin,
  output logic [NIB_W-1:0] SUM,
  output logic             CARRY
);

  logic [NIB_W:0] c;

  // Chain of full adders, bit 0 first
  always_comb begin
    c    = '0;
    SUM  = '0;
    c[0] = Cin;
    for (int i = 0; i < NIB_W; i++) begin
      SUM[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign CARRY = c[NIB_W];

endmodule

// File: rtl/rca_multiword_adder.sv
// Sequential wide adder: reuses one 4-bit ripple-carry slice across NIBBLES
// nibbles, least-significant first, one nibble per clock.
// Ports: clk, rst (sync, active-high), start (sampled in IDLE), a/b/cin
// (latched on accept), busy (RUN), done (1-cycle pulse), sum/cout/overflow
// (registered result, updated only on completion).
module rca_multiword_adder
  import rca_multiword_adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                   cout,
  output logic                   overflow
);

  localparam int unsigned W  = NIB_W * NIBBLES;
  localparam int unsigned IW = clog2_min1(NIBBLES);

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic            carry_reg, carry_n;
  logic [W-1:0]    a_reg, a_n;
  logic [W-1:0]    b_reg, b_n;
  logic [W-1:0]    partial, partial_n;
  logic [W-1:0]    sum_n;
  logic            cout_n, overflow_n, busy_n, done_n;

  logic [NIB_W-1:0] add_a, add_b, add_sum;
  logic             add_carry;

  // Current nibble pair selected by the slice index
  assign add_a = a_reg[idx*NIB_W +: NIB_W];
  assign add_b = b_reg[idx*NIB_W +: NIB_W];

  RIPPLE_CARRY_ADDER u_rca (
    .A     (add_a),
    .B     (add_b),
    .Cin   (carry_reg),
    .SUM   (add_sum),
    .CARRY (add_carry)
  );

  // Next-state and datapath update
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    carry_n    = carry_reg;
    a_n        = a_reg;
    b_n        = b_reg;
    partial_n  = partial;
    sum_n      = sum;
    cout_n     = cout;
    overflow_n = overflow;

    case (state)
      ST_IDLE: begin
        if (start) begin
          a_n       = a;
          b_n       = b;
          carry_n   = cin;
          idx_n     = '0;
          partial_n = '0;
          state_n   = ST_RUN;
        end
      end
      ST_RUN: begin
        partial_n[idx*NIB_W +: NIB_W] = add_sum;
        carry_n = add_carry;
        idx_n   = idx + IW'(1);
        if (idx == IW'(NIBBLES - 1)) begin
          // Publish the full result only once every slice is in
          idx_n      = '0;
          state_n    = ST_DONE;
          sum_n      = partial_n;
          cout_n     = add_carry;
          overflow_n = (a_reg[W-1] == b_reg[W-1]) && (partial_n[W-1] != a_reg[W-1]);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n == ST_RUN);
    done_n = (state_n == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      partial   <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      carry_reg <= carry_n;
      a_reg     <= a_n;
      b_reg     <= b_n;
      partial   <= partial_n;
      sum       <= sum_n;
      cout      <= cout_n;
      overflow  <= overflow_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_rca_multiword_adder.sv
// Bench for rca_multiword_adder: a 4-nibble and a 1-nibble instance share
// stimulus; a latency/arithmetic model checks both every cycle, and directed
// operations pin hand-computed results.
module tb_rca_multiword_adder;

  logic        clk, rst, start, cin;
  logic [15:0] a, b;

  logic        busy4, done4, cout4, ovf4;
  logic [15:0] sum4;
  logic        busy1, done1, cout1, ovf1;
  logic [3:0]  sum1;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;
  int done4_cnt = 0;

  rca_multiword_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  rca_multiword_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a[3:0]), .b(b[3:0]), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = 16-bit build, index 1 = 4-bit build
  logic        m_busy [2];
  logic        m_done [2];
  int          m_left [2];
  logic [16:0] m_res  [2];
  logic        m_as   [2];
  logic        m_bs   [2];
  logic [15:0] m_sum  [2];
  logic        m_cout [2];
  logic        m_ovf  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int w;
      logic [16:0] mask, aa, bb, r;
      w    = (k == 0) ? 16 : 4;
      mask = (k == 0) ? 17'h0FFFF : 17'h0000F;
      if (rst) begin
        m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_left[k] <= 0;
        m_sum[k]  <= '0;   m_cout[k] <= 1'b0; m_ovf[k]  <= 1'b0;
        m_res[k]  <= '0;   m_as[k]   <= 1'b0; m_bs[k]   <= 1'b0;
      end else if (m_done[k]) begin
        m_done[k] <= 1'b0;
      end else if (m_busy[k]) begin
        if (m_left[k] == 1) begin
          r = m_res[k];
          m_busy[k] <= 1'b0;
          m_done[k] <= 1'b1;
          m_sum[k]  <= r[15:0] & mask[15:0];
          m_cout[k] <= r[w];
          m_ovf[k]  <= (m_as[k] == m_bs[k]) && (r[w-1] != m_as[k]);
        end else begin
          m_left[k] <= m_left[k] - 1;
        end
      end else if (start) begin
        aa = {1'b0, a} & mask;
        bb = {1'b0, b} & mask;
        m_busy[k] <= 1'b1;
        m_left[k] <= w / 4;
        m_res[k]  <= aa + bb + 17'(cin);
        m_as[k]   <= a[w-1];
        m_bs[k]   <= b[w-1];
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("busy4", 32'(busy4), 32'(m_busy[0]));
      check("done4", 32'(done4), 32'(m_done[0]));
      check("sum4",  32'(sum4),  32'(m_sum[0]));
      check("cout4", 32'(cout4), 32'(m_cout[0]));
      check("ovf4",  32'(ovf4),  32'(m_ovf[0]));
      check("busy1", 32'(busy1), 32'(m_busy[1]));
      check("done1", 32'(done1), 32'(m_done[1]));
      check("sum1",  32'(sum1),  32'(m_sum[1]));
      check("cout1", 32'(cout1), 32'(m_cout[1]));
      check("ovf1",  32'(ovf1),  32'(m_ovf[1]));
      check("busy_done_excl4", 32'(busy4 & done4), 32'd0);
      if (done4) done4_cnt++;
    end
  end

  // Start one op, wait for the chosen instance's done, check latency and result
  task automatic run_op(input int which, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] es, input logic ec,
                        input logic eo, input int elat);
    int edges;
    int busy_cyc;
    logic d;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; cin = cv;
    @(negedge clk);
    start = 1'b0; a = 16'hA5A5; b = 16'h5A5A; cin = 1'b0;
    edges = 0;
    busy_cyc = 0;
    d = (which == 0) ? done4 : done1;
    while (!d && edges < 20) begin
      if (((which == 0) ? busy4 : busy1) == 1'b1) busy_cyc++;
      @(negedge clk);
      edges++;
      d = (which == 0) ? done4 : done1;
    end
    check("done_seen", 32'(d), 32'd1);
    check("latency", 32'(edges), 32'(elat));
    check("busy_cycles", 32'(busy_cyc), 32'(elat));
    if (which == 0) begin
      check("lit_sum4",  32'(sum4),  32'(es));
      check("lit_cout4", 32'(cout4), 32'(ec));
      check("lit_ovf4",  32'(ovf4),  32'(eo));
    end else begin
      check("lit_sum1",  32'(sum1),  32'(es));
      check("lit_cout1", 32'(cout1), 32'(ec));
      check("lit_ovf1",  32'(ovf1),  32'(eo));
    end
    // let the wide instance return to IDLE
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int cnt0;
    rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b1;
    @(posedge clk);
    started = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_sum",  32'(sum4),  32'h0);
    check("rst_cout", 32'(cout4), 32'd0);
    check("rst_ovf",  32'(ovf4),  32'd0);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    check("no_accept_in_rst", 32'(busy4), 32'd0);

    run_op(0, 16'h000D, 16'h000D, 1'b0, 16'h001A, 1'b0, 1'b0, 4);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
    run_op(0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 4);

    // start pulses while RUN and DONE must be ignored
    cnt0 = done4_cnt;
    @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF;
    for (int i = 0; i < 20 && !done4; i++) @(negedge clk);
    check("ign_done", 32'(done4), 32'd1);
    check("ign_sum",  32'(sum4), 32'h3333);
    @(negedge clk);
    start = 1'b0; a = 16'h0; b = 16'h0;
    check("ign_idle", 32'(busy4), 32'd0);
    repeat (6) @(negedge clk);
    check("ign_hold_sum", 32'(sum4), 32'h3333);
    check("ign_one_done", 32'(done4_cnt - cnt0), 32'd1);

    // reset during the second RUN cycle aborts without done
    cnt0 = done4_cnt;
    @(negedge clk);
    start = 1'b1; a = 16'h5555; b = 16'h5555; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_sum",  32'(sum4),  32'h0);
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'(done4_cnt - cnt0), 32'd0);

    run_op(0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 4);

    // single-slice build
    run_op(1, 16'h000D, 16'h000D, 1'b1, 16'h000B, 1'b1, 1'b0, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
